// File: rtl/conv_linear_pkg.sv
// Shared helpers for the convolution linear post-processing stages:
// width helpers, the half-up rounding constant and the saturation bounds.
package conv_linear_pkg;

  // Width of the kernel-index sideband and the parameter buffer address.
  localparam int USER_W = 16;

  // A full signed W x W product.
  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  // One guard bit above the product so the rounding add and the bias add cannot wrap.
  function automatic int sum_width(input int w);
    return 2 * w + 1;
  endfunction

  // Half an LSB of the shifted result: 2^(f-1).
  function automatic logic [127:0] round_const(input int f);
    return 128'(1) << (f - 1);
  endfunction

  // Largest representable signed W-bit value.
  function automatic logic signed [127:0] sat_max(input int w);
    return (128'sd1 <<< (w - 1)) - 128'sd1;
  endfunction

  // Smallest representable signed W-bit value.
  function automatic logic signed [127:0] sat_min(input int w);
    return -(128'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/axis_linear_apply_pipe_if.sv
// Bundle of the conv-result AXIS slave, the parameter-buffer read port and
// the result AXIS master. "master" is the pipeline's view, "slave" the
// view of the surrounding datapath (stream source, buffer and sink).
interface axis_linear_apply_pipe_if
  import conv_linear_pkg::*;
#(
  parameter int kernal_param_data_width = 16
) ();

  logic                                      linear_pars_buf_load_completed;

  logic signed [kernal_param_data_width-1:0] s_axis_conv_data;
  logic [USER_W-1:0]                         s_axis_conv_user;
  logic                                      s_axis_conv_last;
  logic                                      s_axis_conv_valid;
  logic                                      s_axis_conv_ready;

  logic                                      linear_pars_buffer_ren_s0;
  logic                                      linear_pars_buffer_ren_s1;
  logic [USER_W-1:0]                         linear_pars_buffer_raddr;
  logic signed [kernal_param_data_width-1:0] linear_pars_buffer_dout_a;
  logic signed [kernal_param_data_width-1:0] linear_pars_buffer_dout_b;

  logic signed [kernal_param_data_width-1:0] m_axis_res_data;
  logic                                      m_axis_res_last;
  logic                                      m_axis_res_valid;
  logic                                      m_axis_res_ready;

  modport master (
    input  linear_pars_buf_load_completed,
    input  s_axis_conv_data, s_axis_conv_user, s_axis_conv_last, s_axis_conv_valid,
    output s_axis_conv_ready,
    output linear_pars_buffer_ren_s0, linear_pars_buffer_ren_s1, linear_pars_buffer_raddr,
    input  linear_pars_buffer_dout_a, linear_pars_buffer_dout_b,
    output m_axis_res_data, m_axis_res_last, m_axis_res_valid,
    input  m_axis_res_ready
  );

  modport slave (
    output linear_pars_buf_load_completed,
    output s_axis_conv_data, s_axis_conv_user, s_axis_conv_last, s_axis_conv_valid,
    input  s_axis_conv_ready,
    input  linear_pars_buffer_ren_s0, linear_pars_buffer_ren_s1, linear_pars_buffer_raddr,
    output linear_pars_buffer_dout_a, linear_pars_buffer_dout_b,
    input  m_axis_res_data, m_axis_res_last, m_axis_res_valid,
    output m_axis_res_ready
  );

endinterface

// File: rtl/linear_round_sat.sv
// Combinational tail of A*X + B: half-up rounding of the Q-format product,
// arithmetic shift back to integer, bias add and saturation to W bits.
module linear_round_sat
  import conv_linear_pkg::*;
#(
  parameter int kernal_param_data_width = 16,
  parameter int a_frac_width            = 8
) (
  input  logic signed [2*kernal_param_data_width-1:0] prod,
  input  logic signed [kernal_param_data_width-1:0]   b,
  output logic signed [kernal_param_data_width-1:0]   res
);

  localparam int W      = kernal_param_data_width;
  localparam int PROD_W = prod_width(W);
  localparam int SUM_W  = sum_width(W);

  localparam logic signed [SUM_W-1:0] RND  = SUM_W'(round_const(a_frac_width));
  localparam logic signed [SUM_W-1:0] MAXV = SUM_W'(sat_max(W));
  localparam logic signed [SUM_W-1:0] MINV = SUM_W'(sat_min(W));

  logic signed [SUM_W-1:0] sum;

  // Add half an LSB, then floor-shift: ties round towards +inf.
  function automatic logic signed [SUM_W-1:0] round_shift(input logic signed [PROD_W-1:0] p);
    logic signed [SUM_W-1:0] t;
    t = SUM_W'(p) + RND;
    return t >>> a_frac_width;
  endfunction

  // Clamp the wide sum into the signed W-bit range.
  function automatic logic signed [W-1:0] saturate(input logic signed [SUM_W-1:0] s);
    if (s > MAXV) begin
      return MAXV[W-1:0];
    end else if (s < MINV) begin
      return MINV[W-1:0];
    end
    return s[W-1:0];
  endfunction

  // Round, add the sign-extended bias and saturate.
  always_comb begin
    sum = round_shift(prod) + SUM_W'(b);
    res = saturate(sum);
  end

endmodule

// File: rtl/axis_linear_apply_pipe.sv
// Applies the per-kernel linear parameters (A, B) to tagged conv results:
// result = sat(round(A*X) + B). Four register stages, one sample per clock,
// a single global advance enable provides full backpressure.
module axis_linear_apply_pipe
  import conv_linear_pkg::*;
#(
  parameter int kernal_param_data_width = 16,
  parameter int a_frac_width            = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  axis_linear_apply_pipe_if.master bus
);

  localparam int W      = kernal_param_data_width;
  localparam int PROD_W = prod_width(W);

  logic                     en;
  logic                     hs;
  logic                     vld_p1, vld_p2, vld_p3;
  logic signed [W-1:0]      x_p1, x_p2;
  logic                     last_p1, last_p2, last_p3;
  logic signed [PROD_W-1:0] prod_p3;
  logic signed [W-1:0]      b_p3;
  logic signed [W-1:0]      res;

  // Every stage moves together; the output register is free or being drained.
  assign en = ~bus.m_axis_res_valid | bus.m_axis_res_ready;

  // P0: accept and launch the buffer read in the handshake cycle.
  assign bus.s_axis_conv_ready         = rst_n & en & bus.linear_pars_buf_load_completed;
  assign hs                            = bus.s_axis_conv_valid & bus.s_axis_conv_ready;
  assign bus.linear_pars_buffer_ren_s0 = hs;
  assign bus.linear_pars_buffer_raddr  = bus.s_axis_conv_user;

  // P1: second buffer read stage only fires when the pipe advances, so the
  // buffer's output register stays aligned with the sample in P2.
  assign bus.linear_pars_buffer_ren_s1 = rst_n & en & vld_p1;

  // Valid chain; reset discards every in-flight sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else if (en) begin
      vld_p1 <= hs;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  // Data stages P1 -> P2 -> P3; A and B are read from the buffer in P2.
  always_ff @(posedge clk) begin
    if (en) begin
      x_p1    <= bus.s_axis_conv_data;
      last_p1 <= bus.s_axis_conv_last;
      // P1 -> P2
      x_p2    <= x_p1;
      last_p2 <= last_p1;
      // P2 -> P3: full-width signed product
      prod_p3 <= PROD_W'(x_p2) * PROD_W'(bus.linear_pars_buffer_dout_a);
      b_p3    <= bus.linear_pars_buffer_dout_b;
      last_p3 <= last_p2;
    end
  end

  linear_round_sat #(
    .kernal_param_data_width(W),
    .a_frac_width           (a_frac_width)
  ) u_round_sat (
    .prod(prod_p3),
    .b   (b_p3),
    .res (res)
  );

  // P3 -> output register; holds steady while the sink stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.m_axis_res_valid <= 1'b0;
      bus.m_axis_res_last  <= 1'b0;
      bus.m_axis_res_data  <= '0;
    end else if (en) begin
      bus.m_axis_res_valid <= vld_p3;
      bus.m_axis_res_last  <= last_p3;
      bus.m_axis_res_data  <= res;
    end
  end

endmodule

// File: tb/tb_axis_linear_apply_pipe.sv
// Bench for axis_linear_apply_pipe: parameter-buffer model, reference model of
// sat(round_half_up(A*X / 2^F) + B) fed on every input handshake, and one
// negedge compare process for outputs, handshake rules and stall stability.
module tb_axis_linear_apply_pipe;
  import conv_linear_pkg::*;

  localparam int W = 16;
  localparam int F = 8;

  typedef struct {
    logic signed [W-1:0] d;
    logic                l;
  } exp_t;

  logic clk;
  logic rst_n;
  bit   rand_ready;
  int   errors;
  int   checks;

  logic signed [W-1:0] mem_a [16];
  logic signed [W-1:0] mem_b [16];
  logic signed [W-1:0] s0_a, s0_b;
  exp_t                exp_q[$];

  bit                  prev_stall;
  logic signed [W-1:0] prev_data;
  logic                prev_last;

  axis_linear_apply_pipe_if #(.kernal_param_data_width(W)) bus ();

  axis_linear_apply_pipe #(
    .kernal_param_data_width(W),
    .a_frac_width           (F)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: floor((A*X + 2^(F-1)) / 2^F) + B, clamped to W bits.
  function automatic logic signed [W-1:0] exp_res(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b,
                                                  input logic signed [W-1:0] x);
    longint n, q, r, hi, lo, den;
    den = longint'(1) << F;
    n   = longint'(a) * longint'(x) + (den / 2);
    q   = n / den;
    if ((n % den) != 0 && n < 0) q = q - 1;
    r  = q + longint'(b);
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -(longint'(1) << (W - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return W'(r);
  endfunction

  function automatic logic signed [W-1:0] rd_a(input logic [USER_W-1:0] u);
    return (u < 16) ? mem_a[u[3:0]] : '0;
  endfunction

  function automatic logic signed [W-1:0] rd_b(input logic [USER_W-1:0] u);
    return (u < 16) ? mem_b[u[3:0]] : '0;
  endfunction

  // Two-stage parameter buffer read port.
  always @(posedge clk) begin
    if (bus.linear_pars_buffer_ren_s0) begin
      s0_a <= rd_a(bus.linear_pars_buffer_raddr);
      s0_b <= rd_b(bus.linear_pars_buffer_raddr);
    end
    if (bus.linear_pars_buffer_ren_s1) begin
      bus.linear_pars_buffer_dout_a <= s0_a;
      bus.linear_pars_buffer_dout_b <= s0_b;
    end
  end

  // Sink ready: random while rand_ready, otherwise held high.
  initial begin
    bus.m_axis_res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_axis_res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: everything sampled mid-cycle, describing the next edge.
  always @(negedge clk) begin
    logic en_m;
    logic in_hs;
    exp_t e;
    en_m  = !bus.m_axis_res_valid || bus.m_axis_res_ready;
    in_hs = bus.s_axis_conv_valid && bus.s_axis_conv_ready;
    chk("s_ready_rule", bus.s_axis_conv_ready, rst_n && en_m && bus.linear_pars_buf_load_completed);
    chk("ren_while_stalled", (bus.linear_pars_buffer_ren_s0 || bus.linear_pars_buffer_ren_s1) && !en_m, 0);
    chk("ren_s0_on_handshake", bus.linear_pars_buffer_ren_s0, in_hs);
    if (!rst_n) chk("ren_s1_in_reset", bus.linear_pars_buffer_ren_s1, 0);
    if (prev_stall) begin
      chk("stall_valid", bus.m_axis_res_valid, 1);
      chk("stall_data", bus.m_axis_res_data, prev_data);
      chk("stall_last", bus.m_axis_res_last, prev_last);
    end
    if (bus.m_axis_res_valid && bus.m_axis_res_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", bus.m_axis_res_data, e.d);
        chk("out_last", bus.m_axis_res_last, e.l);
      end
    end
    if (in_hs) begin
      chk("raddr", bus.linear_pars_buffer_raddr, bus.s_axis_conv_user);
      e.d = exp_res(rd_a(bus.s_axis_conv_user), rd_b(bus.s_axis_conv_user), bus.s_axis_conv_data);
      e.l = bus.s_axis_conv_last;
      exp_q.push_back(e);
    end
    if (!rst_n) exp_q.delete();
    prev_stall = rst_n && bus.m_axis_res_valid && !bus.m_axis_res_ready;
    prev_data  = bus.m_axis_res_data;
    prev_last  = bus.m_axis_res_last;
  end

  task automatic send(input logic signed [W-1:0] x, input logic [USER_W-1:0] u, input logic l);
    int guard;
    guard = 0;
    bus.s_axis_conv_valid = 1'b1;
    bus.s_axis_conv_data  = x;
    bus.s_axis_conv_user  = u;
    bus.s_axis_conv_last  = l;
    @(negedge clk);
    while (!bus.s_axis_conv_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("send_timeout", guard, 0);
    @(posedge clk);
    #1;
    bus.s_axis_conv_valid = 1'b0;
  endtask

  // One sample through an idle pipe with the sink always ready.
  task automatic run_one(input string name, input logic signed [W-1:0] x,
                         input logic [USER_W-1:0] u, input logic signed [W-1:0] exp);
    int k;
    send(x, u, 1'b0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.m_axis_res_valid && k < 20);
    chk({name, "_latency"}, k, 4);
    chk(name, bus.m_axis_res_data, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || bus.m_axis_res_valid) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_timeout", guard >= 1000, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached with %0d errors", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors     = 0;
    checks     = 0;
    rand_ready = 1'b0;
    prev_stall = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    rst_n                              = 1'b0;
    bus.linear_pars_buf_load_completed = 1'b1;
    bus.s_axis_conv_valid              = 1'b0;
    bus.s_axis_conv_data               = '0;
    bus.s_axis_conv_user               = '0;
    bus.s_axis_conv_last               = 1'b0;

    // Pin the reference model with hand-computed values.
    chk("model_2x100p5", exp_res(16'sh0200, 16'sd5, 16'sd100), 205);
    chk("model_half_neg", exp_res(16'sh0080, 16'sd0, -16'sd3), -1);
    chk("model_half_pos", exp_res(16'sh0080, 16'sd0, 16'sd3), 2);
    chk("model_sat_neg", exp_res(16'sh7FFF, -16'sd32768, -16'sd32768), -32768);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.m_axis_res_valid, 0);
    chk("rst_data", bus.m_axis_res_data, 0);
    chk("rst_last", bus.m_axis_res_last, 0);
    chk("rst_ready", bus.s_axis_conv_ready, 0);
    chk("rst_ren_s0", bus.linear_pars_buffer_ren_s0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    mem_a[1] = 16'sh0080; mem_b[1] = 16'sd0;
    mem_a[2] = 16'sh7FFF; mem_b[2] = 16'sh7FFF;
    mem_a[3] = 16'sh0200; mem_b[3] = 16'sd5;
    mem_a[4] = 16'sh7FFF; mem_b[4] = -16'sd32768;
    repeat (2) begin @(posedge clk); #1; end

    run_one("dir_205", 16'sd100, 16'd3, 16'sd205);
    run_one("dir_round_m1p5", -16'sd3, 16'd1, -16'sd1);
    run_one("dir_round_1p5", 16'sd3, 16'd1, 16'sd2);
    run_one("dir_sat_pos", 16'sh7FFF, 16'd2, 16'sh7FFF);
    run_one("dir_sat_neg", -16'sd32768, 16'd4, -16'sd32768);
    run_one("dir_bad_kernel", 16'sd77, 16'd200, 16'sd0);

    // Parameter buffer not loaded: nothing accepted until it is.
    bus.linear_pars_buf_load_completed = 1'b0;
    bus.s_axis_conv_valid = 1'b1;
    bus.s_axis_conv_data  = 16'sd11;
    bus.s_axis_conv_user  = 16'd3;
    bus.s_axis_conv_last  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("noload_ready", bus.s_axis_conv_ready, 0);
      chk("noload_ren_s0", bus.linear_pars_buffer_ren_s0, 0);
    end
    @(posedge clk);
    #1;
    bus.linear_pars_buf_load_completed = 1'b1;
    @(negedge clk);
    chk("load_ready_now", bus.s_axis_conv_ready, 1);
    chk("load_ren_s0_now", bus.linear_pars_buffer_ren_s0, 1);
    @(posedge clk);
    #1;
    bus.s_axis_conv_valid = 1'b0;
    drain();

    // Randomized stream with a random sink.
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = W'($urandom);
      mem_b[i] = W'($urandom);
    end
    mem_a[5] = 16'sh7FFF;
    mem_a[6] = -16'sd32768;
    rand_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      send(W'($urandom), USER_W'(i % 8), i == 63);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
      end
    end
    drain();
    rand_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Reset with three samples in flight.
    bus.s_axis_conv_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.s_axis_conv_data = W'(100 + 50 * i);
      bus.s_axis_conv_user = 16'd3;
      bus.s_axis_conv_last = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.s_axis_conv_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_valid", bus.m_axis_res_valid, 0);
    chk("midrst_data", bus.m_axis_res_data, 0);
    chk("midrst_last", bus.m_axis_res_last, 0);
    repeat (10) @(negedge clk);
    chk("midrst_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
